// File: rtl/axi_rd_arbiter.sv
// Round-robin N-master arbiter for the AXI4-Lite read channel (AR/R), one read outstanding.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_rd_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NM-1:0]    m_ARvalid,
  output logic [NM-1:0]    m_ARready,
  input  logic [NM*AW-1:0] m_ARdata,
  input  logic [NM*3-1:0]  m_ARprot,
  output logic [NM-1:0]    m_Rvalid,
  input  logic [NM-1:0]    m_RReady,
  output logic [DW-1:0]    m_Rdata,
  output logic             s_ARvalid,
  input  logic             s_ARready,
  output logic [AW-1:0]    s_ARdata,
  output logic [2:0]       s_ARprot,
  input  logic             s_Rvalid,
  output logic             s_RReady,
  input  logic [DW-1:0]    s_Rdata,
  output logic [NM-1:0]    grant,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake rule: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and once s_ARvalid rises it holds with stable
  // address/prot until s_ARready is seen.

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] win_idx;
  logic [AW-1:0] ar_addr [NM];
  logic [2:0]    ar_prot [NM];
  logic          r_done;

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign ar_addr[i] = m_ARdata[i*AW +: AW];
    assign ar_prot[i] = m_ARprot[i*3 +: 3];
  end

`ifdef ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last assignment.
  always_comb begin
    win_idx = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (m_ARvalid[k]) win_idx = PW'(k);
    end
  end
`else
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NM) s = s - NM;
    return PW'(s);
  endfunction

  // Scan offsets from the top down so the smallest offset from ptr wins.
  always_comb begin
    win_idx = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (m_ARvalid[wrap_idx(ptr, k)]) win_idx = wrap_idx(ptr, k);
    end
  end
`endif

  assign s_ARvalid = (state == ADDR);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign m_ARready = (state == ADDR && s_ARready) ? grant : '0;
  assign m_Rvalid  = (state == DATA && s_Rvalid) ? grant : '0;
  assign s_RReady  = (state == DATA) && |(m_RReady & grant);
  assign m_Rdata   = s_Rdata;
  assign r_done    = s_Rvalid && s_RReady;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      g_idx    <= '0;
      grant    <= '0;
      s_ARdata <= '0;
      s_ARprot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_ARvalid) begin
            g_idx    <= win_idx;
            grant    <= NM'(1) << win_idx;
            s_ARdata <= ar_addr[win_idx];
            s_ARprot <= ar_prot[win_idx];
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (s_ARready) state <= DATA;
        end
        DATA: begin
          if (r_done) begin
            state <= IDLE;
            grant <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr   <= (g_idx == PW'(NM - 1)) ? '0 : g_idx + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
